// File: rtl/tdma_job_sched.sv
// tdma_job_sched: grants one tensor command at a time to the frontend,
// round-robin across requesters, and counts completions per requester.
// Optional feature macro: TDMA_SCHED_PRIO0_EN (requester 0 gets strict
// priority; round-robin applies only among requesters 1..NUM_REQ-1).
module tdma_job_sched #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned CMD_WIDTH = 544,
    parameter int unsigned ID_WIDTH  = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][CMD_WIDTH-1:0]    req_cmd_i,
    output logic                                 start_o,
    output logic [CMD_WIDTH-1:0]                 cmd_o,
    input  logic                                 finished_i,
    output logic                                 busy_o,
    output logic [$clog2(NUM_REQ)-1:0]           owner_o,
    output logic [NUM_REQ-1:0]                   done_o,
    output logic [NUM_REQ-1:0][ID_WIDTH-1:0]     done_id_o,
    output logic                                 err_o
);

    localparam int unsigned OW = $clog2(NUM_REQ);

`ifdef TDMA_SCHED_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] win_c;
    logic [OW-1:0] scan_c;
    logic          any_c;
    logic          grant_c;
    logic          done_c;
    logic [OW-1:0] owner_inc_c;

    // Winner selection: first valid requester scanning upward from rr_ptr.
    always_comb begin
        win_c  = '0;
        any_c  = 1'b0;
        scan_c = rr_ptr;
        if (PRIO0 && req_valid_i[0]) begin
            any_c = 1'b1;
            win_c = '0;
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_c && req_valid_i[scan_c] && !(PRIO0 && (scan_c == '0))) begin
                any_c = 1'b1;
                win_c = scan_c;
            end
            scan_c = (32'(scan_c) == NUM_REQ - 1) ? '0 : scan_c + 1'b1;
        end
    end

    // Pointer value that follows the current owner, wrapping at NUM_REQ.
    always_comb begin
        owner_inc_c = (32'(owner_o) == NUM_REQ - 1) ? '0 : owner_o + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state, same-cycle accept and completion strobe.
    always_comb begin
        state_nxt   = state;
        req_ready_o = '0;
        grant_c     = 1'b0;
        done_c      = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_c) begin
                    req_ready_o[win_c] = 1'b1;
                    grant_c            = 1'b1;
                    state_nxt          = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (finished_i) begin
                    done_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Launch side: capture the winning command and owner, pulse start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_o   <= '0;
            owner_o <= '0;
            start_o <= 1'b0;
        end else begin
            start_o <= grant_c;
            if (grant_c) begin
                cmd_o   <= req_cmd_i[win_c];
                owner_o <= win_c;
            end
        end
    end

    // Busy spans LAUNCH and WAIT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_o <= 1'b0;
        end else if (grant_c) begin
            busy_o <= 1'b1;
        end else if (done_c) begin
            busy_o <= 1'b0;
        end
    end

    // Completion side: done pulse, per-owner counter, pointer advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_o    <= '0;
            done_id_o <= '0;
            rr_ptr    <= '0;
        end else begin
            done_o <= '0;
            if (done_c) begin
                done_o[owner_o]    <= 1'b1;
                done_id_o[owner_o] <= done_id_o[owner_o] + ID_WIDTH'(1);
                rr_ptr             <= owner_inc_c;
            end
        end
    end

    // A completion outside WAIT has no job to retire; flag it until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (finished_i && (state != WAIT)) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: doc/tdma_job_sched.md
TDMA_JOB_SCHED -- requirements
Module: tdma_job_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning number of command requesters (2..8).
REQ-002 SHALL have parameter CMD_WIDTH, default 544, meaning width of one packed tensor command (addresses, strides, shape).
REQ-003 SHALL have parameter ID_WIDTH, default 32, meaning width of the per-requester completion counters.
REQ-004 SHALL have port clk_i  in  1  the single clock; one clock only.
REQ-005 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid_i  in  NUM_REQ  per-requester command valid.
REQ-007 SHALL have port req_ready_o  out  NUM_REQ  per-requester command accept.
REQ-008 SHALL have port req_cmd_i  in  NUM_REQ x CMD_WIDTH  per-requester command.
REQ-009 SHALL have port start_o  out  1  one-cycle launch pulse to the tensor frontend.
REQ-010 SHALL have port cmd_o  out  CMD_WIDTH  registered command presented to the frontend.
REQ-011 SHALL have port finished_i  in  1  one-cycle frontend completion pulse.
REQ-012 SHALL have port busy_o  out  1  job in flight.
REQ-013 SHALL have port owner_o  out  $clog2(NUM_REQ)  index of the granted requester.
REQ-014 SHALL have port done_o  out  NUM_REQ  per-requester completion pulse.
REQ-015 SHALL have port done_id_o  out  NUM_REQ x ID_WIDTH  per-requester completed-job count.
REQ-016 SHALL have port err_o  out  1  sticky spurious-completion flag.

Function
REQ-017 SHALL implement FSM states IDLE, LAUNCH, WAIT.
REQ-018 In IDLE with any req_valid_i set, SHALL pick a winner round-robin starting at rr_ptr, assert only that req_ready_o combinationally in the same cycle, register its cmd into cmd_o, capture owner_o, and go to LAUNCH.
REQ-019 req_ready_o SHALL be all-zero outside IDLE; at most one bit SHALL be set in any cycle.
REQ-020 In LAUNCH, start_o SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-021 cmd_o and owner_o SHALL stay stable from LAUNCH until the FSM returns to IDLE.
REQ-022 busy_o SHALL be 1 in LAUNCH and WAIT and 0 in IDLE.
REQ-023 In WAIT, finished_i=1 SHALL produce done_o[owner]=1 in the next cycle, increment done_id_o[owner] by 1 (mod 2^ID_WIDTH), set rr_ptr=(owner+1) mod NUM_REQ, and enter IDLE.
REQ-024 Accept-to-start latency SHALL be 1 cycle; finished-to-next-grant latency SHALL be 1 cycle, with a new grant possible in the same cycle done_o pulses.
REQ-025 finished_i in IDLE or LAUNCH SHALL be ignored for FSM and counters, and SHALL set err_o, which stays 1 until reset.
REQ-026 A requester lowering valid without a grant SHALL NOT be granted; its valid is not latched.

Reset
REQ-027 On rst_ni=0, asynchronously: FSM=IDLE, rr_ptr=0, cmd_o=0, owner_o=0, start_o=0, done_o=0, done_id_o=0, err_o=0, busy_o=0.
REQ-028 Reset during LAUNCH or WAIT SHALL abandon the job with no done_o pulse; the first grant after reset SHALL go to the lowest-index valid requester.

Configuration
REQ-029 Macro TDMA_SCHED_PRIO0_EN: when defined, requester 0 SHALL win in IDLE whenever req_valid_i[0]=1, and round-robin SHALL apply only among requesters 1..NUM_REQ-1; when undefined, pure round-robin over all requesters per REQ-018.

Verification
REQ-030 Single request: req_valid_i=01 with cmd=0xA5 -> req_ready_o=01 same cycle, start_o next cycle, cmd_o=0xA5, finished_i -> done_o=01, done_id_o[0]=1.
REQ-031 Contention: req_valid_i=11 held for 4 jobs -> grants in order 0,1,0,1; done_id_o[0]=2, done_id_o[1]=2.
REQ-032 Spurious: finished_i pulse in IDLE -> err_o=1, no done_o, counters unchanged.
REQ-033 Back-to-back: finished_i at cycle t with requester 1 waiting -> done_o at t+1, req_ready_o[1]=1 at t+1, start_o at t+2.
REQ-034 Reset mid-WAIT: assert rst_ni=0 -> busy_o=0 immediately, no done_o, all done_id_o=0.
REQ-035 With TDMA_SCHED_PRIO0_EN defined: req_valid_i=11 held for 3 jobs -> requester 0 granted all 3; without the macro, grants 0,1,0.
